// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between two requesters (round-robin,
// or fixed priority when ALU_ARB_FIXED_PRIO_EN is defined); one transaction in flight.
module alu_share_arb #(
    parameter int         NREQ   = 2,
    parameter int         W      = 32,
    parameter logic [3:0] OP_ADD = 4'd0,
    parameter logic [3:0] OP_BEQ = 4'd10,
    parameter logic [3:0] OP_BNE = 4'd11,
    parameter logic [3:0] OP_BLT = 4'd12,
    parameter logic [3:0] OP_BGE = 4'd13
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [W-1:0]    req_data1_0,
    input  logic [W-1:0]    req_data2_0,
    input  logic [W-1:0]    req_imm_0,
    input  logic            req_sel_0,
    input  logic [3:0]      req_op_0,
    input  logic [W-1:0]    req_data1_1,
    input  logic [W-1:0]    req_data2_1,
    input  logic [W-1:0]    req_imm_1,
    input  logic            req_sel_1,
    input  logic [3:0]      req_op_1,
    output logic [W-1:0]    alu_data1,
    output logic [W-1:0]    alu_data2,
    output logic [W-1:0]    alu_imm,
    output logic            alu_sel,
    output logic [3:0]      alu_op,
    input  logic [W-1:0]    alu_c,
    input  logic            alu_bf,
    output logic [NREQ-1:0] rsp_valid,
    input  logic [NREQ-1:0] rsp_ready,
    output logic [W-1:0]    rsp_c,
    output logic            rsp_bf
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state;
    logic   gnt, g, is_br;
`ifdef ALU_ARB_FIXED_PRIO_EN
    assign g = ~req_valid[0];
`else
    logic rr_last;
    assign g = (&req_valid) ? ~rr_last : ~req_valid[0];
`endif
    assign req_ready = (state == IDLE && |req_valid) ? (g ? 2'b10 : 2'b01) : 2'b00;
    // the ALU leaves bf stale on non-branch ops, so only branch ops pass it through
    assign is_br = alu_op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            rsp_valid <= '0;
            rsp_c     <= '0;
            rsp_bf    <= 1'b0;
            alu_data1 <= '0;
            alu_data2 <= '0;
            alu_imm   <= '0;
            alu_sel   <= 1'b0;
            alu_op    <= OP_ADD;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_last   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    alu_data1 <= g ? req_data1_1 : req_data1_0;
                    alu_data2 <= g ? req_data2_1 : req_data2_0;
                    alu_imm   <= g ? req_imm_1 : req_imm_0;
                    alu_sel   <= g ? req_sel_1 : req_sel_0;
                    alu_op    <= g ? req_op_1 : req_op_0;
                    gnt       <= g;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    rr_last   <= g;
`endif
                    state     <= EXEC;
                end
                EXEC: begin
                    rsp_c     <= alu_c;
                    rsp_bf    <= is_br & alu_bf;
                    rsp_valid <= gnt ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: if (rsp_ready[gnt]) begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed + randomized bench for alu_share_arb with a behavioural
// ALU and a transaction-level reference model (honours ALU_ARB_FIXED_PRIO_EN).
module tb_alu_share_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] d1 [2];
    logic [31:0] d2 [2];
    logic [31:0] imm [2];
    logic        sel [2];
    logic [3:0]  op [2];
    logic [31:0] alu_data1, alu_data2, alu_imm, alu_c, rsp_c;
    logic        alu_sel, alu_bf, rsp_bf;
    logic [3:0]  alu_op;

    int vectors = 0, miscompares = 0;
    int dens [2];
    logic busy;
    int age, cur_g, last, cyc, acc_cyc, first_v_cyc;
    logic [31:0] exp_c, last_c;
    logic exp_bf, last_bf;
    logic [1:0] accepted, prev_v, last_v;
    int glog [$];

    alu_share_arb dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data1_0(d1[0]), .req_data2_0(d2[0]), .req_imm_0(imm[0]), .req_sel_0(sel[0]), .req_op_0(op[0]),
        .req_data1_1(d1[1]), .req_data2_1(d2[1]), .req_imm_1(imm[1]), .req_sel_1(sel[1]), .req_op_1(op[1]),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_imm(alu_imm), .alu_sel(alu_sel), .alu_op(alu_op),
        .alu_c(alu_c), .alu_bf(alu_bf), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rsp_c), .rsp_bf(rsp_bf)
    );

    initial forever #5 clk = ~clk;

    // behavioural ALU; non-branch ops drive a junk bf to imitate a stale flag
    function automatic logic [32:0] alu_fn(logic [3:0] o, logic [31:0] a, logic [31:0] b);
        case (o)
            4'd0:    return {^a, a + b};
            4'd1:    return {^a, a - b};
            4'd2:    return {^a, a & b};
            4'd3:    return {^a, a | b};
            4'd4:    return {^a, a ^ b};
            4'd5:    return {^a, a << b[4:0]};
            4'd6:    return {^a, a >> b[4:0]};
            4'd7:    return {^a, 32'($signed(a) >>> b[4:0])};
            4'd8:    return {^a, 31'b0, $signed(a) < $signed(b)};
            4'd9:    return {^a, 31'b0, a < b};
            4'd10:   return {a == b, a - b};
            4'd11:   return {a != b, a - b};
            4'd12:   return {$signed(a) < $signed(b), a - b};
            4'd13:   return {$signed(a) >= $signed(b), a - b};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    assign {alu_bf, alu_c} = alu_fn(alu_op, alu_data1, alu_sel ? alu_imm : alu_data2);

    task automatic chk(string tag, logic [32:0] obs, logic [32:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        busy = 1'b0;
        last = 1;
        prev_v = 2'b00;
        accepted = 2'b00;
    endtask

    task automatic new_req(int i);
        op[i]  = 4'($urandom_range(0, 15));
        d1[i]  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
        d2[i]  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
        imm[i] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
        sel[i] = 1'($urandom_range(0, 1));
        req_valid[i] = 1'b1;
    endtask

    task automatic set_req(int i, logic [3:0] o, logic [31:0] a, logic [31:0] b, logic [31:0] im, logic s);
        op[i] = o; d1[i] = a; d2[i] = b; imm[i] = im; sel[i] = s; req_valid[i] = 1'b1;
    endtask

    // negedge monitor: one transaction at a time, result two cycles after accept
    task automatic mon();
        logic [1:0] er, ev;
        logic [32:0] r;
        int g;
        cyc++;
        if (busy) age++;
        ev = (busy && age >= 2) ? 2'(1 << cur_g) : 2'b00;
`ifdef ALU_ARB_FIXED_PRIO_EN
        g = req_valid[0] ? 0 : 1;
`else
        g = (req_valid == 2'b11) ? 1 - last : (req_valid[0] ? 0 : 1);
`endif
        er = (busy || req_valid == 2'b00) ? 2'b00 : 2'(1 << g);
        chk("req_ready", 33'(req_ready), 33'(er));
        chk("rsp_valid", 33'(rsp_valid), 33'(ev));
        if (ev != 2'b00) begin
            chk("rsp_c", 33'(rsp_c), 33'(exp_c));
            chk("rsp_bf", 33'(rsp_bf), 33'(exp_bf));
        end
        if (rsp_valid != 2'b00) begin
            if (prev_v == 2'b00) first_v_cyc = cyc;
            last_c = rsp_c; last_bf = rsp_bf; last_v = rsp_valid;
        end
        prev_v = rsp_valid;
        accepted = 2'b00;
        if (ev != 2'b00 && rsp_ready[cur_g]) busy = 1'b0;
        if (er != 2'b00) begin
            r = alu_fn(op[g], d1[g], sel[g] ? imm[g] : d2[g]);
            exp_c = r[31:0];
            exp_bf = (op[g] inside {4'd10, 4'd11, 4'd12, 4'd13}) ? r[32] : 1'b0;
            busy = 1'b1; age = 0; cur_g = g; last = g; acc_cyc = cyc;
            accepted[g] = 1'b1;
            glog.push_back(g);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (accepted[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && $urandom_range(0, 99) < dens[i]) new_req(i);
        end
    endtask

    task automatic drain();
        dens[0] = 0; dens[1] = 0;
        rsp_ready = 2'b11;
        for (int k = 0; k < 30 && (req_valid != 2'b00 || busy); k++) tick();
        chk("drain", {31'b0, req_valid != 2'b00, busy}, 33'b0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00; rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            d1[i] = '0; d2[i] = '0; imm[i] = '0; sel[i] = 1'b0; op[i] = '0; dens[i] = 0;
        end
        cyc = 0; age = 0; cur_g = 0; first_v_cyc = 0; acc_cyc = 0;
        last_c = '0; last_bf = 1'b0; last_v = 2'b00; exp_c = '0; exp_bf = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 33'(rsp_valid), 33'b0);
        chk("rst_req_ready", 33'(req_ready), 33'b0);
        chk("rst_rsp_c", 33'(rsp_c), 33'b0);
        chk("rst_alu_op", 33'(alu_op), 33'b0);
        rst = 1'b0;

        // single ADD 5+7 on req 0
        set_req(0, 4'd0, 32'd5, 32'd7, 32'd99, 1'b0);
        rsp_ready = 2'b11;
        repeat (4) tick();
        chk("add_c", 33'(last_c), 33'd12);
        chk("add_bf", 33'(last_bf), 33'b0);
        chk("add_valid", 33'(last_v), 33'b01);
        chk("add_latency", 33'(first_v_cyc - acc_cyc), 33'd2);

        // asynchronous reset between clock edges
        rst = 1'b1;
        #1;
        chk("arst_rsp_valid", 33'(rsp_valid), 33'b0);
        chk("arst_req_ready", 33'(req_ready), 33'b0);
        chk("arst_rsp_c", 33'(rsp_c), 33'b0);
        rst = 1'b0;
        model_reset();

        // BEQ on req 1 via immediate
        set_req(1, 4'd10, 32'd3, 32'd8, 32'd3, 1'b1);
        repeat (4) tick();
        chk("beq_bf", 33'(last_bf), 33'b1);
        chk("beq_valid", 33'(last_v), 33'b10);

        // contention: both requesters keep valid high
        glog.delete();
        dens[0] = 100; dens[1] = 100;
        new_req(0); new_req(1);
        for (int k = 0; k < 60 && glog.size() < 6; k++) tick();
        for (int i = 0; i < 6; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            chk($sformatf("grant%0d", i), 33'(glog.size() > i ? glog[i] : 9), 33'd0);
`else
            chk($sformatf("grant%0d", i), 33'(glog.size() > i ? glog[i] : 9), 33'(i % 2));
`endif
        end
        drain();

        // backpressure: SUB 10-3 held while req 1 waits
        set_req(0, 4'd1, 32'd10, 32'd3, 32'd0, 1'b0);
        rsp_ready = 2'b00;
        tick();
        new_req(1);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("bp_req_ready", 33'(req_ready), 33'b0);
        end
        chk("bp_c", 33'(last_c), 33'd7);
        chk("bp_valid", 33'(rsp_valid), 33'b01);
        rsp_ready = 2'b01;
        drain();

        // reset while in EXEC with rr_last pointing at req 0
        set_req(0, 4'd0, 32'd1, 32'd2, 32'd0, 1'b0);
        rsp_ready = 2'b11;
        tick();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        glog.delete();
        new_req(0); new_req(1);
        repeat (6) tick();
        chk("rst_exec_grant", 33'(glog.size() > 0 ? glog[0] : 9), 33'd0);
        drain();

        // randomized traffic with random response backpressure
        dens[0] = 60; dens[1] = 60;
        for (int k = 0; k < 1500; k++) begin
            rsp_ready = 2'($urandom_range(0, 3));
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
